// File: rtl/plc_ton_timer.sv
// PLC on-delay timer (TON) with tick time base, RES clear and loadable preset.
// Define PLC_TON_RETENTIVE_EN to build the retentive variant (RTO) instead.
module plc_ton_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        rung_in,
  input  logic        res_in,
  input  logic        pre_load,
  input  logic [31:0] pre_in,
  output logic        en,
  output logic        tt,
  output logic        dn,
  output logic [31:0] acc,
  output logic [31:0] pre
);

  localparam int unsigned W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TIMING = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_pre;
  logic           r_en;
  logic           r_tt;
  logic           r_dn;
  logic [W-1:0]   w_acc_nxt;
  logic [W-1:0]   w_pre_eff;
  logic [W-1:0]   w_acc_inc;
  logic           w_en_nxt;
  logic           w_tt_nxt;
  logic           w_dn_nxt;

  // A preset loaded this cycle already governs this cycle's compare.
  assign w_pre_eff = pre_load ? pre_in : r_pre;

  // Ticks only count while timing; saturate rather than wrap.
  assign w_acc_inc = (r_state == S_TIMING && tick && r_acc != {W{1'b1}})
                     ? r_acc + W'(1) : r_acc;

  // Next state, accumulator and registered status bits.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_en_nxt    = rung_in;
    w_tt_nxt    = 1'b0;
    w_dn_nxt    = 1'b0;

    if (res_in) begin
      w_acc_nxt = '0;
      if (!rung_in)
        w_state_nxt = S_IDLE;
      else if (w_pre_eff == '0)
        w_state_nxt = S_DONE;
      else
        w_state_nxt = S_TIMING;
    end else if (!rung_in) begin
`ifdef PLC_TON_RETENTIVE_EN
      w_acc_nxt = (r_acc > w_pre_eff) ? w_pre_eff : r_acc;
      if (r_state == S_DONE && r_acc >= w_pre_eff)
        w_state_nxt = S_DONE;
      else
        w_state_nxt = S_IDLE;
`else
      w_acc_nxt   = '0;
      w_state_nxt = S_IDLE;
`endif
    end else begin
      // Rung true: reaching or passing the preset pins acc at PRE.
      if (w_acc_inc >= w_pre_eff) begin
        w_acc_nxt   = w_pre_eff;
        w_state_nxt = S_DONE;
      end else begin
        w_acc_nxt   = w_acc_inc;
        w_state_nxt = S_TIMING;
      end
    end

    w_tt_nxt = (w_state_nxt == S_TIMING);
    w_dn_nxt = (w_state_nxt == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_pre   <= '0;
      r_en    <= 1'b0;
      r_tt    <= 1'b0;
      r_dn    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_pre   <= w_pre_eff;
      r_en    <= w_en_nxt;
      r_tt    <= w_tt_nxt;
      r_dn    <= w_dn_nxt;
    end
  end

  assign en  = r_en;
  assign tt  = r_tt;
  assign dn  = r_dn;
  assign acc = r_acc;
  assign pre = r_pre;

endmodule

// File: tb/tb_plc_ton_timer.sv
// Directed self-checking bench for plc_ton_timer (TON build, RTO branches under macro).
module tb_plc_ton_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        rung_in;
  logic        res_in;
  logic        pre_load;
  logic [31:0] pre_in;
  logic        en;
  logic        tt;
  logic        dn;
  logic [31:0] acc;
  logic [31:0] pre;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  plc_ton_timer dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .rung_in  (rung_in),
    .res_in   (res_in),
    .pre_load (pre_load),
    .pre_in   (pre_in),
    .en       (en),
    .tt       (tt),
    .dn       (dn),
    .acc      (acc),
    .pre      (pre)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
    end
  endtask

  task automatic load_pre(input logic [31:0] v);
    pre_load = 1'b1; pre_in = v; cyc();
    pre_load = 1'b0;
  endtask

  task automatic clear();
    res_in = 1'b1; rung_in = 1'b0; tick = 1'b0; cyc();
    res_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 1'b1; rung_in = 1'b1; res_in = 1'b0;
    pre_load = 1'b1; pre_in = 32'd9;
    cyc(); cyc();
    n_cmp++; if ({en, tt, dn} !== 3'b000) begin n_err++; $display("FAIL reset_bits got %b want 000", {en, tt, dn}); end
    n_cmp++; if (acc !== 32'd0) begin n_err++; $display("FAIL reset_acc got %0d want 0", acc); end
    n_cmp++; if (pre !== 32'd0) begin n_err++; $display("FAIL reset_pre got %0d want 0", pre); end
    rst = 1'b1; tick = 1'b0; rung_in = 1'b0; pre_load = 1'b0; pre_in = 32'd0;
    cyc();
  endtask

  task automatic test_basic_timing();
    load_pre(32'd5);
    n_cmp++; if (pre !== 32'd5) begin n_err++; $display("FAIL basic_pre got %0d want 5", pre); end
    n_cmp++; if ({en, tt, dn} !== 3'b000) begin n_err++; $display("FAIL basic_idle got %b want 000", {en, tt, dn}); end
    rung_in = 1'b1; cyc();
    n_cmp++; if ({en, tt, dn} !== 3'b110 || acc !== 32'd0) begin n_err++; $display("FAIL basic_start got bits %b acc %0d want 110 acc 0", {en, tt, dn}, acc); end
    for (int k = 1; k <= 5; k++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      n_cmp++; if (acc !== 32'(k)) begin n_err++; $display("FAIL basic_acc%0d got %0d want %0d", k, acc, k); end
      n_cmp++; if ({en, tt, dn} !== ((k < 5) ? 3'b110 : 3'b101)) begin n_err++; $display("FAIL basic_bits%0d got %b want %b", k, {en, tt, dn}, (k < 5) ? 3'b110 : 3'b101); end
      cyc(); cyc();
      n_cmp++; if (acc !== 32'(k)) begin n_err++; $display("FAIL basic_hold%0d got %0d want %0d", k, acc, k); end
    end
    tick = 1'b1; cyc(); tick = 1'b0;
    n_cmp++; if (acc !== 32'd5 || dn !== 1'b1) begin n_err++; $display("FAIL done_ignores_tick got acc %0d dn %b want 5 1", acc, dn); end
    clear();
  endtask

  task automatic test_rung_drop();
    load_pre(32'd10);
    rung_in = 1'b1; cyc();
    do_ticks(4);
    n_cmp++; if (acc !== 32'd4) begin n_err++; $display("FAIL drop_pre_acc got %0d want 4", acc); end
    rung_in = 1'b0; tick = 1'b1; cyc(); tick = 1'b0;
    n_cmp++; if ({en, tt} !== 2'b00) begin n_err++; $display("FAIL drop_bits got %b want 00", {en, tt}); end
`ifdef PLC_TON_RETENTIVE_EN
    n_cmp++; if (acc !== 32'd4) begin n_err++; $display("FAIL drop_acc got %0d want 4", acc); end
    rung_in = 1'b1; cyc();
    do_ticks(6);
    n_cmp++; if (dn !== 1'b1 || acc !== 32'd10) begin n_err++; $display("FAIL rto_resume got dn %b acc %0d want 1 10", dn, acc); end
`else
    n_cmp++; if (acc !== 32'd0) begin n_err++; $display("FAIL drop_acc got %0d want 0", acc); end
`endif
    clear();
  endtask

  task automatic test_pre_zero();
    load_pre(32'd0);
    rung_in = 1'b1; cyc();
    n_cmp++; if ({en, tt, dn} !== 3'b101 || acc !== 32'd0) begin n_err++; $display("FAIL pre_zero got bits %b acc %0d want 101 acc 0", {en, tt, dn}, acc); end
    clear();
  endtask

  task automatic test_preload_clamp();
    load_pre(32'd20);
    rung_in = 1'b1; cyc();
    do_ticks(12);
    n_cmp++; if (acc !== 32'd12 || tt !== 1'b1) begin n_err++; $display("FAIL clamp_setup got acc %0d tt %b want 12 1", acc, tt); end
    pre_load = 1'b1; pre_in = 32'd8; cyc(); pre_load = 1'b0;
    n_cmp++; if (acc !== 32'd8 || {tt, dn} !== 2'b01 || pre !== 32'd8) begin n_err++; $display("FAIL clamp_lower got acc %0d tt/dn %b pre %0d want 8 01 8", acc, {tt, dn}, pre); end
    clear();
    load_pre(32'd20);
    rung_in = 1'b1; cyc();
    do_ticks(12);
    pre_load = 1'b1; pre_in = 32'd13; tick = 1'b1; cyc(); pre_load = 1'b0; tick = 1'b0;
    n_cmp++; if (acc !== 32'd13 || {tt, dn} !== 2'b01) begin n_err++; $display("FAIL clamp_tick got acc %0d tt/dn %b want 13 01", acc, {tt, dn}); end
    clear();
  endtask

  task automatic test_res_priority();
    load_pre(32'd20);
    rung_in = 1'b1; cyc();
    do_ticks(7);
    res_in = 1'b1; tick = 1'b1; cyc(); res_in = 1'b0; tick = 1'b0;
    n_cmp++; if (acc !== 32'd0 || {en, tt, dn} !== 3'b110) begin n_err++; $display("FAIL res_prio got acc %0d bits %b want 0 110", acc, {en, tt, dn}); end
    tick = 1'b1; cyc(); tick = 1'b0;
    n_cmp++; if (acc !== 32'd1) begin n_err++; $display("FAIL res_resume got %0d want 1", acc); end
    do_ticks(6);
    rst = 1'b0; tick = 1'b1; cyc(); rst = 1'b1; tick = 1'b0;
    n_cmp++; if ({en, tt, dn} !== 3'b000 || acc !== 32'd0 || pre !== 32'd0) begin n_err++; $display("FAIL rst_mid got bits %b acc %0d pre %0d want 000 0 0", {en, tt, dn}, acc, pre); end
    cyc();
    n_cmp++; if ({en, tt, dn} !== 3'b101 || acc !== 32'd0) begin n_err++; $display("FAIL rst_restart got bits %b acc %0d want 101 0", {en, tt, dn}, acc); end
    clear();
  endtask

  task automatic test_back_to_back();
    pre_load = 1'b1; pre_in = 32'd3; rung_in = 1'b1; cyc(); pre_load = 1'b0;
    n_cmp++; if (tt !== 1'b1 || pre !== 32'd3) begin n_err++; $display("FAIL b2b_start got tt %b pre %0d want 1 3", tt, pre); end
    tick = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_cmp++; if (acc !== 32'((k < 3) ? k : 3) || dn !== (k >= 3)) begin n_err++; $display("FAIL b2b_%0d got acc %0d dn %b want %0d %b", k, acc, dn, (k < 3) ? k : 3, k >= 3); end
    end
    tick = 1'b0;
    clear();
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; rung_in = 1'b0; res_in = 1'b0;
    pre_load = 1'b0; pre_in = 32'd0;
    test_reset();
    test_basic_timing();
    test_rung_drop();
    test_pre_zero();
    test_preload_clamp();
    test_res_priority();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
